// File: rtl/nubus_pkg.sv
// Shared types and constants for the NuBus local-memory arbiter.
package nubus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLV  = 2'd1,
        CPU  = 2'd2
    } arb_state_t;

    localparam logic [1:0]  OWN_NONE  = 2'd0;
    localparam logic [1:0]  OWN_SLV   = 2'd1;
    localparam logic [1:0]  OWN_CPU   = 2'd2;
    localparam logic [31:0] RDATA_ERR = 32'hFFFF_FFFF;

endpackage

// File: rtl/nubus_memarb_wdog.sv
// Access watchdog: counts stalled cycles of the current access and flags expiry at LIMIT.
module nubus_memarb_wdog #(
    parameter int LIMIT = 255
) (
    input  logic nub_clkn,
    input  logic nub_reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge nub_clkn or posedge nub_reset) begin
        if (nub_reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (cnt == W'(LIMIT));

endmodule

// File: rtl/nubus_mem_arbiter.sv
// Two-requester (NuBus slave / local CPU) arbiter for the card's single memory port.
// Optional access watchdog enabled by defining NUBUS_MEMARB_TIMEOUT_EN.
module nubus_mem_arbiter
    import nubus_pkg::*;
#(
    parameter int SLV_BURST      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        nub_clkn,
    input  logic        nub_reset,
    input  logic        s_valid,
    input  logic [31:0] s_addr,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_ready,
    output logic [31:0] s_rdata,
    input  logic        c_valid,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [3:0]  c_wstrb,
    output logic        c_ready,
    output logic [31:0] c_rdata,
    output logic        err,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  owner
);

    localparam logic [3:0] BURST_LIM = 4'(SLV_BURST);

    arb_state_t  state, next_state;
    logic [3:0]  starve;
    logic        grant_s, grant_c;
    logic        busy, done, timed_out, wd_expire;
    logic [31:0] done_rdata;

    assign busy      = (state != IDLE);
    assign timed_out = busy && wd_expire && !mem_ready;
    assign done      = busy && (mem_ready || timed_out);
    assign done_rdata = timed_out ? RDATA_ERR : mem_rdata;

`ifdef NUBUS_MEMARB_TIMEOUT_EN
    nubus_memarb_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .nub_clkn  (nub_clkn),
        .nub_reset (nub_reset),
        .clr       (grant_s || grant_c),
        .en        (busy && !mem_ready),
        .expire    (wd_expire)
    );
`else
    // No watchdog: the limit only appears here so it is still referenced.
    assign wd_expire = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        next_state = state;
        grant_s    = 1'b0;
        grant_c    = 1'b0;
        case (state)
            IDLE: begin
                // Slave wins ties until the CPU has been passed over SLV_BURST times.
                if (s_valid && (!c_valid || starve != BURST_LIM)) begin
                    grant_s    = 1'b1;
                    next_state = SLV;
                end else if (c_valid) begin
                    grant_c    = 1'b1;
                    next_state = CPU;
                end
            end
            SLV, CPU: begin
                if (done) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge nub_clkn or posedge nub_reset) begin
        if (nub_reset) begin
            state     <= IDLE;
            starve    <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            state <= next_state;
            if (grant_s) begin
                mem_valid <= 1'b1;
                mem_addr  <= s_addr;
                mem_wdata <= s_wdata;
                mem_wstrb <= s_wstrb;
                if (!c_valid)                starve <= '0;
                else if (starve != BURST_LIM) starve <= starve + 1'b1;
            end else if (grant_c) begin
                mem_valid <= 1'b1;
                mem_addr  <= c_addr;
                mem_wdata <= c_wdata;
                mem_wstrb <= c_wstrb;
                starve    <= '0;
            end else if (done) begin
                mem_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        s_ready = 1'b0;
        c_ready = 1'b0;
        s_rdata = '0;
        c_rdata = '0;
        owner   = OWN_NONE;
        case (state)
            SLV: begin
                owner   = OWN_SLV;
                s_ready = done;
                s_rdata = done ? done_rdata : '0;
            end
            CPU: begin
                owner   = OWN_CPU;
                c_ready = done;
                c_rdata = done ? done_rdata : '0;
            end
            default: owner = OWN_NONE;
        endcase
    end

    assign err = timed_out;

endmodule

// File: tb/tb_nubus_mem_arbiter.sv
// Directed self-checking bench for nubus_mem_arbiter (watchdog tests when NUBUS_MEMARB_TIMEOUT_EN is defined).
module tb_nubus_mem_arbiter;

    logic        nub_clkn = 1'b0;
    logic        nub_reset;
    logic        s_valid, c_valid, mem_ready;
    logic [31:0] s_addr, s_wdata, c_addr, c_wdata, mem_rdata;
    logic [3:0]  s_wstrb, c_wstrb;
    logic        s_ready, c_ready, err, mem_valid;
    logic [31:0] s_rdata, c_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [1:0]  owner;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 nub_clkn = ~nub_clkn;

    nubus_mem_arbiter #(
        .SLV_BURST      (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .nub_clkn  (nub_clkn),
        .nub_reset (nub_reset),
        .s_valid   (s_valid),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .c_valid   (c_valid),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_wstrb   (c_wstrb),
        .c_ready   (c_ready),
        .c_rdata   (c_rdata),
        .err       (err),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .owner     (owner)
    );

    task automatic tick();
        @(posedge nub_clkn);
        #1;
    endtask

    task automatic test_reset();
        nub_reset = 1'b1;
        s_valid = 1'b0; c_valid = 1'b0; mem_ready = 1'b1;
        s_addr = '0; s_wdata = '0; s_wstrb = '0;
        c_addr = '0; c_wdata = '0; c_wstrb = '0;
        mem_rdata = 32'hDEAD_BEEF;
        tick(); tick();
        #1;
        n_tests++;
        if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid got %b want 0", mem_valid); end
        n_tests++;
        if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        n_tests++;
        if (mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h/%h want 0/0", mem_wdata, mem_wstrb); end
        n_tests++;
        if (s_ready !== 1'b0 || c_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b%b want 00", s_ready, c_ready); end
        n_tests++;
        if (s_rdata !== 32'h0 || c_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h/%h want 0/0", s_rdata, c_rdata); end
        n_tests++;
        if (err !== 1'b0 || owner !== 2'd0) begin n_fail++; $display("FAIL reset_err_owner got %b/%0d want 0/0", err, owner); end
        nub_reset = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_slave_read();
        s_valid = 1'b1; s_addr = 32'hF500_0010; s_wstrb = 4'h0;
        tick();
        s_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hA5A5_1234;
        #1;
        n_tests++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'hF500_0010) begin n_fail++; $display("FAIL slv_read_mem got %b/%h want 1/f5000010", mem_valid, mem_addr); end
        n_tests++;
        if (s_ready !== 1'b1 || s_rdata !== 32'hA5A5_1234) begin n_fail++; $display("FAIL slv_read_ready got %b/%h want 1/a5a51234", s_ready, s_rdata); end
        n_tests++;
        if (c_ready !== 1'b0 || c_rdata !== 32'h0 || owner !== 2'd1) begin n_fail++; $display("FAIL slv_read_nonowner got %b/%h/%0d want 0/0/1", c_ready, c_rdata, owner); end
        tick();
        mem_ready = 1'b0;
        #1;
        n_tests++;
        if (mem_valid !== 1'b0 || s_ready !== 1'b0 || owner !== 2'd0) begin n_fail++; $display("FAIL slv_read_idle got %b/%b/%0d want 0/0/0", mem_valid, s_ready, owner); end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_own [10] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        int bad_own = 0;
        int bad_rdy = 0;
        int bad_idle = 0;
        nub_reset = 1'b1;
        #2;
        nub_reset = 1'b0;
        s_valid = 1'b1; s_addr = 32'h0000_1000;
        c_valid = 1'b1; c_addr = 32'h0000_2000;
        mem_ready = 1'b1; mem_rdata = 32'h0BAD_F00D;
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            if (owner !== exp_own[i]) begin
                bad_own++;
                $display("FAIL fair_owner[%0d] got %0d want %0d", i, owner, exp_own[i]);
            end
            if (exp_own[i] == 2'd1) begin
                if (s_ready !== 1'b1 || c_ready !== 1'b0 || mem_addr !== 32'h0000_1000) begin
                    bad_rdy++;
                    $display("FAIL fair_slv[%0d] got %b%b/%h want 10/00001000", i, s_ready, c_ready, mem_addr);
                end
            end else begin
                if (c_ready !== 1'b1 || s_ready !== 1'b0 || c_rdata !== 32'h0BAD_F00D || mem_addr !== 32'h0000_2000) begin
                    bad_rdy++;
                    $display("FAIL fair_cpu[%0d] got %b%b/%h/%h want 01/0badf00d/00002000", i, s_ready, c_ready, c_rdata, mem_addr);
                end
            end
            tick();
            if (mem_valid !== 1'b0 || owner !== 2'd0) begin
                bad_idle++;
                $display("FAIL fair_idle[%0d] got %b/%0d want 0/0", i, mem_valid, owner);
            end
        end
        n_tests++;
        if (bad_own != 0) n_fail++;
        n_tests++;
        if (bad_rdy != 0) n_fail++;
        n_tests++;
        if (bad_idle != 0) n_fail++;
        s_valid = 1'b0; c_valid = 1'b0; mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_cpu_write_wait();
        int pulses = 0;
        int unstable = 0;
        c_valid = 1'b1; c_addr = 32'h0000_0040; c_wdata = 32'h1234_5678; c_wstrb = 4'b0011;
        tick();
        c_valid = 1'b0; c_wdata = 32'hFFFF_0000; c_wstrb = 4'b1111; c_addr = 32'h0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            if (mem_valid !== 1'b1 || mem_wdata !== 32'h1234_5678 || mem_wstrb !== 4'b0011 || mem_addr !== 32'h0000_0040) begin
                unstable++;
                $display("FAIL cpu_wr_stable[%0d] got %b/%h/%b want 1/12345678/0011", i, mem_valid, mem_wdata, mem_wstrb);
            end
            if (c_ready === 1'b1) pulses++;
            if (i < 3 && c_ready !== 1'b0) $display("FAIL cpu_wr_early[%0d] got %b want 0", i, c_ready);
            tick();
        end
        mem_ready = 1'b0;
        #1;
        if (c_ready === 1'b1) pulses++;
        n_tests++;
        if (unstable != 0) n_fail++;
        n_tests++;
        if (pulses != 1) begin n_fail++; $display("FAIL cpu_wr_pulses got %0d want 1", pulses); end
        n_tests++;
        if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL cpu_wr_done got %b want 0", mem_valid); end
    endtask

    task automatic test_reset_mid_access();
        c_valid = 1'b1; c_addr = 32'h0000_0080; c_wstrb = 4'h0;
        tick();
        c_valid = 1'b0;
        tick();
        n_tests++;
        if (mem_valid !== 1'b1 || owner !== 2'd2) begin n_fail++; $display("FAIL rst_mid_pre got %b/%0d want 1/2", mem_valid, owner); end
        nub_reset = 1'b1;
        #1;
        mem_ready = 1'b1;
        #1;
        n_tests++;
        if (mem_valid !== 1'b0 || mem_addr !== 32'h0 || owner !== 2'd0) begin n_fail++; $display("FAIL rst_mid_out got %b/%h/%0d want 0/0/0", mem_valid, mem_addr, owner); end
        n_tests++;
        if (c_ready !== 1'b0 || c_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_mid_ready got %b/%h want 0/0", c_ready, c_rdata); end
        tick();
        nub_reset = 1'b0;
        mem_ready = 1'b0;
        s_valid = 1'b1; s_addr = 32'hF500_0020;
        tick();
        s_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0000_5555;
        #1;
        n_tests++;
        if (owner !== 2'd1 || mem_addr !== 32'hF500_0020 || s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_after got %0d/%h/%b want 1/f5000020/1", owner, mem_addr, s_ready); end
        tick();
        mem_ready = 1'b0;
    endtask

`ifdef NUBUS_MEMARB_TIMEOUT_EN
    task automatic test_timeout();
        int early = 0;
        s_valid = 1'b1; s_addr = 32'hF500_0030; mem_ready = 1'b0; mem_rdata = 32'h1111_2222;
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (s_ready !== 1'b0 || err !== 1'b0 || mem_valid !== 1'b1) early++;
            tick();
        end
        #1;
        n_tests++;
        if (early != 0) begin n_fail++; $display("FAIL tmo_early got %0d bad cycles want 0", early); end
        n_tests++;
        if (s_ready !== 1'b1 || err !== 1'b1 || s_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL tmo_expire got %b/%b/%h want 1/1/ffffffff", s_ready, err, s_rdata); end
        tick();
        n_tests++;
        if (mem_valid !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL tmo_after got %b/%b want 0/0", mem_valid, err); end
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        mem_ready = 1'b1;
        #1;
        n_tests++;
        if (s_ready !== 1'b1 || err !== 1'b0 || s_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL tmo_coincident got %b/%b/%h want 1/0/11112222", s_ready, err, s_rdata); end
        tick();
        mem_ready = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        int bad = 0;
        s_valid = 1'b1; s_addr = 32'hF500_0030; mem_ready = 1'b0; mem_rdata = 32'h1111_2222;
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (s_ready !== 1'b0 || err !== 1'b0 || mem_valid !== 1'b1) bad++;
            tick();
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL no_tmo_wait got %0d bad cycles want 0", bad); end
        mem_ready = 1'b1;
        #1;
        n_tests++;
        if (s_ready !== 1'b1 || err !== 1'b0 || s_rdata !== 32'h1111_2222) begin n_fail++; $display("FAIL no_tmo_done got %b/%b/%h want 1/0/11112222", s_ready, err, s_rdata); end
        tick();
        mem_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_slave_read();
        test_fairness();
        test_cpu_write_wait();
        test_reset_mid_access();
`ifdef NUBUS_MEMARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
